// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one variable-latency memory between instruction fetch
// and the MEM-stage load/store port: data-first with fetch anti-starvation, timeout abort.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall,
  output logic              err
);

  localparam int unsigned SW = 4;
  localparam int unsigned WW = 8;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_e;

  state_e state_q, state_d;

  logic              m_req_q,    m_req_d;
  logic              m_we_q,     m_we_d;
  logic [DATA_W-1:0] m_addr_q,   m_addr_d;
  logic [DATA_W-1:0] m_wdata_q,  m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q,  d_ready_d;
  logic              err_q,      err_d;
  logic [SW-1:0]     starve_q,   starve_d;
  logic [WW-1:0]     wait_q,     wait_d;

  logic d_pend_c;
  logic grant_d_c;
  logic grant_i_c;
  logic timeout_c;

  // Data wins unless a waiting fetch has already been passed over STARVE_LIM times.
  assign d_pend_c  = d_rd | d_wr;
  assign grant_d_c = d_pend_c & (~if_req | (starve_q < STARVE_MAX));
  assign grant_i_c = if_req & ~grant_d_c;
  assign timeout_c = (wait_q == WAIT_LAST);

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      starve_q   <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      err_q      <= err_d;
      starve_q   <= starve_d;
      wait_q     <= wait_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c)      state_d = D_ACC;
        else if (grant_i_c) state_d = I_ACC;
      end
      D_ACC, I_ACC: begin
        if (m_ack || timeout_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; ready/err are single-cycle pulses.
  always_comb begin
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = 1'b0;
    starve_d   = starve_q;
    wait_d     = wait_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          m_req_d   = 1'b1;
          m_we_d    = d_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (if_req && (starve_q < STARVE_MAX)) starve_d = starve_q + SW'(1);
        end else if (grant_i_c) begin
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = if_addr;
          starve_d = '0;
        end
      end
      D_ACC, I_ACC: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          wait_d  = '0;
          if (state_q == D_ACC) begin
            d_ready_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = m_rdata;
          end
        end else if (timeout_c) begin
          // Abort: complete the access with zero data and flag the error.
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          wait_d  = '0;
          err_d   = 1'b1;
          if (state_q == D_ACC) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: ;
    endcase
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign err      = err_q;

  // Freeze the pipeline while any requester is still waiting for its completion pulse.
  assign stall = (if_req & ~if_ready_q) | (d_pend_c & ~d_ready_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the pipelined CPU's instruction-fetch port and its MEM-stage load/store port.
- Sits between the CPU core (instruction address/data, memory address/data, read/write strobes) and the unified memory.
- Serialises accesses, gives priority to data with anti-starvation for fetch, and produces one freeze signal for all pipeline registers.
- Bounds every access with a timeout so a dead memory cannot hang the core.

Parameters:
- DATA_W, 32, width of address and data buses.
- STARVE_LIM, 4, number of consecutive data grants made while a fetch is pending before fetch is forced to win (1..15).
- TIMEOUT, 64, maximum cycles m_req may stay high without m_ack before the access is aborted (2..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  DATA_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_rd  in  1  load request (mem_r).
- d_wr  in  1  store request (mem_w); d_rd and d_wr never both 1.
- d_addr  in  DATA_W  load/store address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- m_req  out  1  memory request; registered.
- m_we  out  1  memory write enable; registered.
- m_addr  out  DATA_W  memory address; registered.
- m_wdata  out  DATA_W  memory write data; registered.
- m_rdata  in  DATA_W  memory read data; valid while m_ack=1.
- m_ack  in  1  memory completion; sampled only while m_req=1.
- stall  out  1  pipeline freeze.
- err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset while rst=0, asynchronous: state IDLE; m_req, m_we, if_ready, d_ready and err are 0; m_addr, m_wdata, if_rdata and d_rdata are 0; starve_cnt and wait_cnt are 0.
- Reset mid-access aborts the access; no ready pulse is generated for it.
- States: IDLE, D_ACC, I_ACC, DONE.
- IDLE, data pending (d_rd|d_wr), and fetch absent or starve_cnt<STARVE_LIM:
  - next state D_ACC; m_req<=1; m_we<=d_wr; m_addr<=d_addr; m_wdata<=d_wdata.
  - starve_cnt increments (saturating at STARVE_LIM) if if_req=1.
- IDLE, fetch pending, and data absent or starve_cnt==STARVE_LIM:
  - next state I_ACC; m_req<=1; m_we<=0; m_addr<=if_addr.
  - starve_cnt<=0.
- D_ACC/I_ACC with m_ack=1:
  - m_req<=0 and m_we<=0; next state DONE; wait_cnt<=0.
  - Matching ready<=1.
  - For a load or fetch, rdata<=m_rdata. A store leaves d_rdata unchanged.
- D_ACC/I_ACC with m_ack=0: wait_cnt increments.
- When wait_cnt reaches TIMEOUT-1 without m_ack:
  - m_req<=0; next state DONE; matching ready<=1; rdata<=0; err<=1.
  - wait_cnt<=0.
- DONE: ready and err are high for exactly this cycle. No request is sampled. Next state is IDLE.
  - Requesters drop or change their request at this edge, since the pipeline advances.
- Minimum latency: request seen in IDLE at edge 0; m_req high from edge 0; m_ack in the following cycle; ready high after edge 1. Total 2 cycles, m_ack same cycle as first m_req.
- stall = (if_req & ~if_ready) | ((d_rd|d_wr) & ~d_ready). Combinational; it freezes PC and all pipeline registers.
- A request arriving while the arbiter is busy waits; it is stable because stall is high.
- m_ack outside D_ACC/I_ACC is ignored.
- Exactly one of if_ready and d_ready can be high in any cycle.

Test Plan:
- Reset/idle: rst=0 mid-D_ACC -> m_req drops immediately; all outputs are 0; after release with no requests, m_req stays 0 and stall=0.
- Fetch only, zero wait: if_req=1, if_addr=0x0000_0040, memory acks in the first m_req cycle with 0x0050_0093 -> if_ready pulses 1 cycle, 2 cycles after the request; if_rdata=0x0050_0093; stall is high for 2 cycles then low.
- Store, 3-cycle wait: d_wr=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> m_we=1 and m_addr=0x100 for 4 cycles; d_ready pulses once; d_rdata is unchanged.
- Simultaneous fetch and load, STARVE_LIM=2: d_rd and if_req held for 3 back-to-back accesses -> grant order D, D, I.
- Starvation reset: in the same run, starve_cnt returns to 0 after the I grant.
- Timeout, TIMEOUT=8: load with m_ack never asserted -> m_req is high for 8 cycles; then d_ready=1, err=1 and d_rdata=0 for one cycle; state returns to IDLE; a next fetch proceeds normally.
- Back-to-back: load acked, then fetch pending in DONE -> no grant in the DONE cycle; I_ACC starts the following cycle.
